// File: rtl/ram_rd_arb_ctrl.sv
// RAM front-end: zero-fill sequencer, write pass-through, round-robin read arbiter.
// Optional macro RAM_RD_ARB_PERR_LOG_EN adds a sticky first-parity-error log.
module ram_rd_arb_ctrl #(
    parameter int NUM_REQ    = 4,
    parameter int DEPTH      = 4,
    parameter int WIDTH      = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reinit,
    output logic                     init_done,
    input  logic                     wr_en,
    input  logic [DEPTH-1:0]         wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     wr_ready,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*DEPTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_perr,
    output logic                     ram_we,
    output logic [DEPTH-1:0]         ram_waddr,
    output logic [WIDTH-1:0]         ram_din,
    output logic                     ram_re,
    output logic [DEPTH-1:0]         ram_raddr,
    input  logic [WIDTH-1:0]         ram_dout,
    input  logic                     ram_perr
`ifdef RAM_RD_ARB_PERR_LOG_EN
    ,
    output logic                       perr_log_vld,
    output logic [DEPTH-1:0]           perr_log_addr,
    output logic [$clog2(NUM_REQ)-1:0] perr_log_id
`endif
);

    localparam int IDW  = $clog2(NUM_REQ);
    localparam int LAST = RD_LATENCY - 1;

    typedef enum logic [1:0] {INIT, RUN, DRAIN} state_t;

    state_t             state;
    state_t             state_next;
    logic [DEPTH-1:0]   init_cnt;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     gnt_id;
    logic               gnt_any;
    logic [NUM_REQ-1:0] gnt_vec;
    logic               pipe_busy;

    logic               pipe_vld  [RD_LATENCY];
    logic [IDW-1:0]     pipe_id   [RD_LATENCY];
`ifdef RAM_RD_ARB_PERR_LOG_EN
    logic [DEPTH-1:0]   pipe_addr [RD_LATENCY];
`endif

    // Round-robin search starting at rr_ptr, wrapping past the top requester
    always_comb begin
        int j;
        j       = 0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!gnt_any && req_valid[j]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(j);
            end
        end
        gnt_vec = gnt_any ? (NUM_REQ'(1) << gnt_id) : '0;
    end

    // Any read still travelling through the tag pipeline
    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < RD_LATENCY; i++) pipe_busy = pipe_busy | pipe_vld[i];
    end

    // Next-state and RAM/user port steering per state
    always_comb begin
        state_next = state;
        init_done  = 1'b0;
        wr_ready   = 1'b0;
        req_ready  = '0;
        ram_we     = 1'b0;
        ram_waddr  = '0;
        ram_din    = '0;
        ram_re     = 1'b0;
        ram_raddr  = '0;
        unique case (state)
            INIT: begin
                ram_we    = 1'b1;
                ram_waddr = init_cnt;
                if (init_cnt == '1) state_next = RUN;
            end
            RUN: begin
                init_done = 1'b1;
                wr_ready  = 1'b1;
                ram_we    = wr_en;
                ram_waddr = wr_addr;
                ram_din   = wr_data;
                req_ready = gnt_vec;
                ram_re    = gnt_any;
                ram_raddr = req_addr[int'(gnt_id)*DEPTH +: DEPTH];
                if (reinit) state_next = DRAIN;
            end
            DRAIN: begin
                if (!pipe_busy) state_next = INIT;
            end
            default: state_next = INIT;
        endcase
    end

    // State, fill counter and arbitration pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
            rr_ptr   <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) init_cnt <= init_cnt + DEPTH'(1);
            else               init_cnt <= '0;
            if (ram_re) begin
                if (gnt_id == IDW'(NUM_REQ - 1)) rr_ptr <= '0;
                else                             rr_ptr <= gnt_id + IDW'(1);
            end
        end
    end

    // Tag pipeline tracking each read through the RAM latency
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_id[i]  <= '0;
`ifdef RAM_RD_ARB_PERR_LOG_EN
                pipe_addr[i] <= '0;
`endif
            end
        end else begin
            pipe_vld[0] <= ram_re;
            pipe_id[0]  <= gnt_id;
`ifdef RAM_RD_ARB_PERR_LOG_EN
            pipe_addr[0] <= ram_raddr;
`endif
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
`ifdef RAM_RD_ARB_PERR_LOG_EN
                pipe_addr[i] <= pipe_addr[i-1];
`endif
            end
        end
    end

    assign rsp_valid = pipe_vld[LAST] ? (NUM_REQ'(1) << pipe_id[LAST]) : '0;
    assign rsp_data  = ram_dout;
    assign rsp_perr  = pipe_vld[LAST] & ram_perr;

`ifdef RAM_RD_ARB_PERR_LOG_EN
    // Sticky capture of the first errored response, cleared on re-fill
    always_ff @(posedge clk) begin
        if (rst || (state == DRAIN && state_next == INIT)) begin
            perr_log_vld  <= 1'b0;
            perr_log_addr <= '0;
            perr_log_id   <= '0;
        end else if (rsp_perr && !perr_log_vld) begin
            perr_log_vld  <= 1'b1;
            perr_log_addr <= pipe_addr[LAST];
            perr_log_id   <= pipe_id[LAST];
        end
    end
`endif

endmodule

// File: tb/tb_ram_rd_arb_ctrl.sv
// Directed bench for ram_rd_arb_ctrl with a 2-cycle read-first RAM model.
// Covers fill, pass-through write, round-robin order, parity, reinit drain and reset.
module tb_ram_rd_arb_ctrl;

  logic        clk;
  logic        rst;
  logic        reinit;
  logic        init_done;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic [3:0]  req_valid;
  logic [15:0] req_addr;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_perr;
  logic        ram_we;
  logic [3:0]  ram_waddr;
  logic [31:0] ram_din;
  logic        ram_re;
  logic [3:0]  ram_raddr;
  logic [31:0] ram_dout;
  logic        ram_perr;
`ifdef RAM_RD_ARB_PERR_LOG_EN
  logic        perr_log_vld;
  logic [3:0]  perr_log_addr;
  logic [1:0]  perr_log_id;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [16];
  logic [31:0] rd1;
  logic [31:0] rd2;

  ram_rd_arb_ctrl #(
    .NUM_REQ(4), .DEPTH(4), .WIDTH(32), .RD_LATENCY(2)
  ) dut (
    .clk(clk), .rst(rst), .reinit(reinit), .init_done(init_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_perr(rsp_perr), .ram_we(ram_we), .ram_waddr(ram_waddr),
    .ram_din(ram_din), .ram_re(ram_re), .ram_raddr(ram_raddr),
    .ram_dout(ram_dout), .ram_perr(ram_perr)
`ifdef RAM_RD_ARB_PERR_LOG_EN
    ,
    .perr_log_vld(perr_log_vld), .perr_log_addr(perr_log_addr),
    .perr_log_id(perr_log_id)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h5A5A_0000 | 32'(i);
    end else if (ram_we) begin
      mem[ram_waddr] <= ram_din;
    end
    if (ram_re) rd1 <= mem[ram_raddr];
    rd2 <= rd1;
  end
  assign ram_dout = rd2;

  task automatic fail(input string tag);
    errors++;
    $error("FAIL %s", tag);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; reinit = 1'b0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; req_valid = 4'hF; req_addr = '0; ram_perr = 1'b0;
    tick(); tick(); settle();
    chk("rst_init_done", 64'(init_done), 64'(0));
    chk("rst_wr_ready", 64'(wr_ready), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_perr", 64'(rsp_perr), 64'(0));
    chk("rst_ram_re", 64'(ram_re), 64'(0));

    req_valid = 4'h0; rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      settle();
      checks += 4;
      if (ram_we !== 1'b1) fail("init_we");
      if (ram_waddr !== 4'(k)) fail("init_waddr");
      if (ram_din !== 32'h0) fail("init_din");
      if (init_done !== 1'b0) fail("init_done_lo");
      tick();
    end
    settle();
    chk("run_init_done", 64'(init_done), 64'(1));
    chk("run_wr_ready", 64'(wr_ready), 64'(1));

    for (int c = 0; c < 18; c++) begin
      if (c < 16) begin
        req_valid = 4'b0001;
        req_addr  = 16'(c);
      end else begin
        req_valid = 4'b0000;
      end
      settle();
      if (c < 16) begin
        chk("fill_grant", 64'(req_ready), 64'(4'b0001));
        chk("fill_raddr", 64'(ram_raddr), 64'(c));
      end
      chk("fill_rsp_valid", 64'(rsp_valid), 64'((c >= 2) ? 1 : 0));
      if (c >= 2) chk("fill_rsp_data", 64'(rsp_data), 64'(0));
      tick();
    end

    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEAD_BEEF;
    settle();
    chk("wr_we", 64'(ram_we), 64'(1));
    chk("wr_waddr", 64'(ram_waddr), 64'(5));
    chk("wr_din", 64'(ram_din), 64'(32'hDEAD_BEEF));
    tick();
    wr_en = 1'b0;
    req_valid = 4'b0100; req_addr = 16'h0500;
    settle();
    chk("r2_grant", 64'(req_ready), 64'(4'b0100));
    chk("r2_re", 64'(ram_re), 64'(1));
    chk("r2_raddr", 64'(ram_raddr), 64'(5));
    tick();
    req_valid = 4'b0000;
    settle();
    chk("r2_rsp_early", 64'(rsp_valid), 64'(0));
    tick(); settle();
    chk("r2_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    chk("r2_rsp_data", 64'(rsp_data), 64'(32'hDEAD_BEEF));

    for (int i = 0; i < 4; i++) begin
      tick();
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 32'h1000 + 32'(i);
    end
    tick();
    wr_en = 1'b0;
    req_valid = 4'b1000; req_addr = 16'h3210;
    settle();
    chk("r3_align_grant", 64'(req_ready), 64'(4'b1000));
    tick();

    req_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) req_valid = 4'h0;
      settle();
      if (c < 8)
        chk("rr_grant", 64'(req_ready), 64'(4'b0001 << (c % 4)));
      if (c == 0) chk("rr_rsp_none", 64'(rsp_valid), 64'(0));
      if (c == 1) begin
        chk("rr_rsp_r3", 64'(rsp_valid), 64'(4'b1000));
        chk("rr_rsp_r3_data", 64'(rsp_data), 64'(32'h1003));
      end
      if (c >= 2) begin
        chk("rr_rsp", 64'(rsp_valid), 64'(4'b0001 << ((c - 2) % 4)));
        chk("rr_rsp_data", 64'(rsp_data),
            64'(32'h1000 + 32'((c - 2) % 4)));
      end
      tick();
    end

    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h0BAD_F00D;
    tick();
    wr_en = 1'b0;
    req_valid = 4'b1000; req_addr = 16'h9210;
    settle();
    chk("pe_grant", 64'(req_ready), 64'(4'b1000));
    tick();
    req_valid = 4'b0000;
    tick();
    ram_perr = 1'b1;
    settle();
    chk("pe_rsp_valid", 64'(rsp_valid), 64'(4'b1000));
    chk("pe_rsp_data", 64'(rsp_data), 64'(32'h0BAD_F00D));
    chk("pe_rsp_perr", 64'(rsp_perr), 64'(1));
    tick(); settle();
    chk("pe_gated", 64'(rsp_perr), 64'(0));
    chk("pe_rsp_idle", 64'(rsp_valid), 64'(0));
    ram_perr = 1'b0;
`ifdef RAM_RD_ARB_PERR_LOG_EN
    chk("log_vld", 64'(perr_log_vld), 64'(1));
    chk("log_addr", 64'(perr_log_addr), 64'(9));
    chk("log_id", 64'(perr_log_id), 64'(3));
    req_valid = 4'b0010; req_addr = 16'h0020;
    tick();
    req_valid = 4'b0000;
    tick();
    ram_perr = 1'b1;
    settle();
    chk("pe2_rsp_perr", 64'(rsp_perr), 64'(1));
    tick();
    ram_perr = 1'b0;
    settle();
    chk("log_sticky_addr", 64'(perr_log_addr), 64'(9));
    chk("log_sticky_id", 64'(perr_log_id), 64'(3));
`endif

    req_valid = 4'b0010; req_addr = 16'h0040;
    settle();
    chk("ri_grant", 64'(req_ready), 64'(4'b0010));
    tick();
    req_valid = 4'b0000; reinit = 1'b1;
    settle();
    chk("ri_still_run", 64'(init_done), 64'(1));
    tick();
    reinit = 1'b0; req_valid = 4'hF;
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hFFFF_FFFF;
    settle();
    chk("dr_init_done", 64'(init_done), 64'(0));
    chk("dr_req_ready", 64'(req_ready), 64'(0));
    chk("dr_wr_ready", 64'(wr_ready), 64'(0));
    chk("dr_ram_we", 64'(ram_we), 64'(0));
    chk("dr_ram_re", 64'(ram_re), 64'(0));
    chk("dr_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
    chk("dr_rsp_data", 64'(rsp_data), 64'(0));
    tick(); settle();
    chk("dr2_req_ready", 64'(req_ready), 64'(0));
    chk("dr2_ram_we", 64'(ram_we), 64'(0));
    chk("dr2_rsp_valid", 64'(rsp_valid), 64'(0));
    tick();
    wr_en = 1'b0;
    for (int k = 0; k < 16; k++) begin
      reinit = (k == 3);
      settle();
      checks += 4;
      if (ram_we !== 1'b1) fail("ri_we");
      if (ram_waddr !== 4'(k)) fail("ri_waddr");
      if (ram_din !== 32'h0) fail("ri_din");
      if (req_ready !== 4'h0) fail("ri_req_ready");
      tick();
    end
    reinit = 1'b0; req_valid = 4'h0;
    settle();
    chk("ri_run", 64'(init_done), 64'(1));
    req_valid = 4'b0001; req_addr = 16'h0005;
    tick();
    req_valid = 4'b0000;
    tick(); settle();
    chk("ri_zero_valid", 64'(rsp_valid), 64'(4'b0001));
    chk("ri_zero_data", 64'(rsp_data), 64'(0));

    req_valid = 4'b0001; req_addr = 16'h0010;
    tick();
    req_valid = 4'b0010;
    settle();
    chk("rf_grant", 64'(req_ready), 64'(4'b0010));
    tick();
    req_valid = 4'b0000; rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("rf_rsp0", 64'(rsp_valid), 64'(0));
    chk("rf_we", 64'(ram_we), 64'(1));
    chk("rf_waddr0", 64'(ram_waddr), 64'(0));
    chk("rf_init_done", 64'(init_done), 64'(0));
    tick(); settle();
    chk("rf_rsp1", 64'(rsp_valid), 64'(0));
    chk("rf_waddr1", 64'(ram_waddr), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_rd_arb_ctrl.md
Name: ram_rd_arb_ctrl

Overview:
Controller that sits in front of one ram_1r1w-style simple dual-port RAM instance.
- After reset, and on request, it sequences a zero-fill of every RAM entry.
- It passes one user write port through to the RAM.
- It shares the single RAM read port among NUM_REQ requesters with round-robin arbitration.
- It tracks each read through the RAM's fixed read latency and returns data plus the parity error to the granted requester.

Parameters:
- NUM_REQ, 4: number of read requesters (2..8).
- DEPTH, 4: RAM address width in bits; the RAM has 2**DEPTH entries.
- WIDTH, 32: RAM data width.
- RD_LATENCY, 2: RAM read latency in cycles (1 or 2); must match the RAM's configured read mode.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- reinit  in  1  one-cycle pulse requesting a RAM re-zero; ignored unless state is RUN
- init_done  out  1  high while state is RUN
- wr_en  in  1  user write enable
- wr_addr  in  DEPTH  user write address
- wr_data  in  WIDTH  user write data
- wr_ready  out  1  user write accepted when wr_en & wr_ready
- req_valid  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ*DEPTH  packed read addresses; requester i uses bits [i*DEPTH +: DEPTH]
- req_ready  out  NUM_REQ  one-hot grant
- rsp_valid  out  NUM_REQ  one-hot response strobe
- rsp_data  out  WIDTH  response data
- rsp_perr  out  1  parity error on this response
- ram_we  out  1  RAM write enable
- ram_waddr  out  DEPTH  RAM write address
- ram_din  out  WIDTH  RAM write data
- ram_re  out  1  RAM read enable
- ram_raddr  out  DEPTH  RAM read address
- ram_dout  in  WIDTH  RAM read data
- ram_perr  in  1  RAM parity error, aligned with ram_dout

Behaviour:
- One clock domain. rst is synchronous and active-high.
- Reset values:
  - state=INIT, init_cnt=0, rr_ptr=0, tag pipeline cleared.
  - init_done=0, wr_ready=0, req_ready=0, rsp_valid=0, rsp_perr=0, ram_re=0.
  - In-flight reads at reset are discarded; no rsp is produced for them.
- FSM states: INIT, RUN, DRAIN.
- INIT:
  - Each cycle: ram_we=1, ram_waddr=init_cnt, ram_din=0, then init_cnt++.
  - When init_cnt = 2**DEPTH-1 is written, next state is RUN and init_cnt resets to 0.
  - INIT lasts exactly 2**DEPTH cycles.
  - wr_ready=0, req_ready=0, ram_re=0.
- RUN:
  - init_done=1, wr_ready=1.
  - Write port passes through combinationally: ram_we=wr_en, ram_waddr=wr_addr, ram_din=wr_data.
  - Read arbitration:
    - req_ready = round-robin one-hot grant among req_valid bits, searching from rr_ptr upward with wrap.
    - Grant is combinational from req_valid; at most one grant per cycle.
    - ram_re = |req_ready; ram_raddr = address of the granted requester.
    - After a grant to requester i, rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
  - reinit=1 moves to DRAIN next cycle. Grants in that same cycle still complete.
- DRAIN:
  - req_ready=0, wr_ready=0, ram_we=0.
  - When the tag pipeline is empty, go to INIT next cycle.
  - init_done=0.
- Tag pipeline:
  - RD_LATENCY stages of {vld, id}; stage 0 loads {ram_re, granted index}.
  - At the last stage: rsp_valid = vld ? onehot(id) : 0, rsp_data = ram_dout, rsp_perr = vld & ram_perr.
  - Read-to-response latency is exactly RD_LATENCY cycles.
  - No response backpressure; requesters must accept every response.
- Hazards:
  - A same-address write and read in the same cycle returns whatever the RAM's read mode defines. No forwarding is done.
  - Back-to-back grants to the same requester are legal when it is the only one valid.
- rsp_data is undefined when rsp_valid=0.

Optional Feature:
- Macro RAM_RD_ARB_PERR_LOG_EN.
- When defined, three extra outputs are added:
  - perr_log_vld (1)
  - perr_log_addr (DEPTH)
  - perr_log_id ($clog2(NUM_REQ))
- These capture the address and requester of the first response with rsp_perr=1, which requires the read address to travel in the tag pipeline.
- The log is sticky until rst or until entry to INIT; later errors do not overwrite it.
- When not defined, these ports and the address field in the tag pipeline do not exist.

Test Plan:
- Release rst, DEPTH=4 → ram_we=1 for exactly 16 cycles with ram_waddr 0..15, ram_din=0; init_done rises on cycle 17. Reads of all entries return 0.
- In RUN, write 0xDEADBEEF to addr 5; then req_valid[2]=1 with addr 5 → req_ready=4'b0100 the same cycle; 2 cycles later rsp_valid=4'b0100, rsp_data=0xDEADBEEF.
- req_valid=4'b1111 held for 8 cycles with rr_ptr=0 → grant order 0,1,2,3,0,1,2,3; responses arrive in the same order, each 2 cycles after its grant.
- Force ram_perr=1 on the response to requester 3 at addr 9 → rsp_perr=1 on that cycle only. With RAM_RD_ARB_PERR_LOG_EN, perr_log_vld=1, perr_log_addr=9, perr_log_id=3; a second error leaves these unchanged.
- Grant requester 1, then pulse reinit in the next cycle → requester 1's response still arrives, then state goes DRAIN→INIT for 16 zero-writes; req_ready=0 throughout.
- Assert rst while two reads are in flight → no rsp_valid afterwards; INIT restarts at addr 0.
